yuv_to_rgb: RTL
===============

# yuv_to_rgb

Pipelined multi-port YUV→RGB colour-space converter with video sync alignment. It restores RGB pixels from full-range BT.601 YUV on the return path of the video pipeline, after YUV-domain processing. It processes C_PORT_NUM pixels per clock and delays HS/VS/DE by the same latency as the pixel data, so downstream timing is unchanged.

## Interface
- C_BPC, 8: bits per colour component (6..12).
- C_PORT_NUM, 4: pixels per clock; port p uses bits [p*C_BPC +: C_BPC] of every bus.
- C_DLY, 3: total latency in clocks, from input to output; must be ≥3; cycles beyond 3 are appended as plain register stages.
- C_BLANK_ZERO, 1: when 1, R/G/B outputs are forced to 0 whenever DE_O=0.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- HS_I / VS_I / DE_I  in  1 each  input syncs.
- Y_I / U_I / V_I  in  C_BPC*C_PORT_NUM each  input luma/chroma; chroma is offset-binary (centre 2^(C_BPC-1)).
- R_O / G_O / B_O  out  C_BPC*C_PORT_NUM each  output pixels.
- HS_O / VS_O / DE_O  out  1 each  syncs delayed by C_DLY.

## Operation
- Let O = 2^(C_BPC-1).
- Each port has an identical, independent lane; there is no cross-port interaction.
- Stage 1 (registered):
  - du = U − O and dv = V − O, signed C_BPC+1 bits.
  - Y is registered alongside, zero-extended.
- Stage 2 (registered) computes the signed products:
  - pr = 359·dv
  - pg = −88·du − 183·dv
  - pb = 454·du
  - Internal width is signed C_BPC+12 bits, which is sufficient and has no overflow.
- Stage 3 (registered):
  - X = Y + ((p + 128) >>> 8), using an arithmetic shift (floor).
  - Clamp X to [0, 2^C_BPC−1].
  - Register the result as R/G/B.
- Coefficients are fixed 8-bit fractions: 1.402, 0.344, 0.714, 1.772 (×256).
- Extra stages (C_DLY−3) form a shift register after stage 3 on R/G/B.
- HS/VS/DE pass through a C_DLY-deep shift register.
- Blanking: with C_BLANK_ZERO=1, R_O/G_O/B_O = 0 whenever DE_O=0. With C_BLANK_ZERO=0, the lanes convert continuously regardless of DE.
- The block has no flow control. One input beat per clock is always accepted; there is no backpressure.

## Timing
- Reset:
  - While rst=1 at a clk edge, every pipeline register and sync delay register is cleared to 0.
  - As a result, R_O=G_O=B_O=0 and HS_O=VS_O=DE_O=0 from the first edge with rst high.
- Latency: input sampled at edge n appears at the outputs after edge n+C_DLY−1 (registered output, C_DLY register stages).
- Reset mid-frame:
  - In-flight data is discarded, and the outputs read 0 for the entire reset duration.
  - After rst falls, the outputs show zeros (shifted-in reset state) for C_DLY−1 further cycles.
  - The first post-reset input then emerges.
- Sync alignment: for every C_DLY, DE_O rises on the same cycle as the first converted pixel of a line; the data/sync skew is 0.
- Clamp boundaries:
  - An exact result of 2^C_BPC−1 passes through unchanged.
  - Any value ≥ 2^C_BPC saturates to 2^C_BPC−1.
  - Any negative value saturates to 0.
- Throughput: 1 beat/clk per port, continuous. Back-to-back lines and frames need no idle gap.

## Test plan
- Neutral grey (C_BPC=8, all ports): Y=128, U=128, V=128 → R=G=B=128 after 3 clocks (C_DLY=3); HS/VS/DE are delayed by exactly 3 clocks.
- Arithmetic and rounding, port 0: Y=81, U=90, V=240 → R=238, G=14, B=14. Ports 1..3 fed Y=255, U=128, V=255 → R=255 (clamped), G=164, B=255.
- Low clamp: Y=0, U=0, V=128 → R=0, G=44, B=0 (B raw −227 saturates to 0).
- Blanking and alignment, C_BLANK_ZERO=1, C_DLY=5:
  - Stimulus: drive a 1920-beat DE line with a ramp Y=0..255, U=V=128, with nonzero YUV during blanking.
  - Expected: R_O=G_O=B_O=0 whenever DE_O=0; pixel k equals Y[k] on all channels; DE_O and the first pixel appear together, 5 clocks after input.
- Mid-stream reset:
  - Stimulus: assert rst for 2 cycles during active video, then release.
  - Expected: all outputs are 0 from the first reset edge, through the reset, and for C_DLY−1 cycles after release; the first post-reset input pixel then appears with correct values and aligned syncs.
- Random regression: 10k random beats at C_BPC=10, C_PORT_NUM=2, checked against a bit-exact reference model of the formulas above, with zero mismatches.

Source files
------------

// File: rtl/yuv_to_rgb.sv
// rtl/yuv_to_rgb.sv - multi-port full-range BT.601 YUV to RGB converter
// Three arithmetic stages plus optional delay stages; syncs ride an equal-depth delay line.
module yuv_to_rgb #(
  parameter int C_BPC        = 8,
  parameter int C_PORT_NUM   = 4,
  parameter int C_DLY        = 3,
  parameter int C_BLANK_ZERO = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          HS_I,
  input  logic                          VS_I,
  input  logic                          DE_I,
  input  logic [C_BPC*C_PORT_NUM-1:0]   Y_I,
  input  logic [C_BPC*C_PORT_NUM-1:0]   U_I,
  input  logic [C_BPC*C_PORT_NUM-1:0]   V_I,
  output logic [C_BPC*C_PORT_NUM-1:0]   R_O,
  output logic [C_BPC*C_PORT_NUM-1:0]   G_O,
  output logic [C_BPC*C_PORT_NUM-1:0]   B_O,
  output logic                          HS_O,
  output logic                          VS_O,
  output logic                          DE_O
);

  localparam int W  = C_BPC * C_PORT_NUM;
  localparam int PW = C_BPC + 12;

  localparam logic signed [C_BPC:0] K_OFS = (C_BPC+1)'(1 << (C_BPC - 1));
  localparam logic signed [PW-1:0]  K_PR  = PW'(359);
  localparam logic signed [PW-1:0]  K_PGU = PW'(88);
  localparam logic signed [PW-1:0]  K_PGV = PW'(183);
  localparam logic signed [PW-1:0]  K_PB  = PW'(454);
  localparam logic signed [PW-1:0]  K_RND = PW'(128);

  // Round-to-nearest of p/256 (floor after +128), add luma, saturate to [0, 2^C_BPC-1].
  function automatic logic [C_BPC-1:0] sat(input logic signed [PW-1:0] p,
                                           input logic [C_BPC-1:0] y);
    logic signed [PW-1:0] s;
    logic signed [PW:0]   x;
    s = (p + K_RND) >>> 8;
    x = {s[PW-1], s} + {{(PW+1-C_BPC){1'b0}}, y};
    if (x[PW])                 sat = '0;
    else if (|x[PW-1:C_BPC])   sat = '1;
    else                       sat = x[C_BPC-1:0];
  endfunction

  logic [W-1:0]   w_r3;
  logic [W-1:0]   w_g3;
  logic [W-1:0]   w_b3;
  logic [3*W-1:0] w_rgb;
  logic           w_blank;

  for (genvar gp = 0; gp < C_PORT_NUM; gp++) begin : g_lane
    logic signed [C_BPC:0] r_du;
    logic signed [C_BPC:0] r_dv;
    logic [C_BPC-1:0]      r_y1;
    logic [C_BPC-1:0]      r_y2;
    logic signed [PW-1:0]  r_pr;
    logic signed [PW-1:0]  r_pg;
    logic signed [PW-1:0]  r_pb;
    logic [C_BPC-1:0]      r_r;
    logic [C_BPC-1:0]      r_g;
    logic [C_BPC-1:0]      r_b;
    logic signed [PW-1:0]  w_dux;
    logic signed [PW-1:0]  w_dvx;

    assign w_dux = {{(PW-C_BPC-1){r_du[C_BPC]}}, r_du};
    assign w_dvx = {{(PW-C_BPC-1){r_dv[C_BPC]}}, r_dv};

    always_ff @(posedge clk) begin
      if (rst) begin
        r_du <= '0;
        r_dv <= '0;
        r_y1 <= '0;
        r_y2 <= '0;
        r_pr <= '0;
        r_pg <= '0;
        r_pb <= '0;
        r_r  <= '0;
        r_g  <= '0;
        r_b  <= '0;
      end else begin
        r_du <= $signed({1'b0, U_I[gp*C_BPC +: C_BPC]}) - K_OFS;
        r_dv <= $signed({1'b0, V_I[gp*C_BPC +: C_BPC]}) - K_OFS;
        r_y1 <= Y_I[gp*C_BPC +: C_BPC];
        r_pr <= w_dvx * K_PR;
        r_pg <= -(w_dux * K_PGU) - (w_dvx * K_PGV);
        r_pb <= w_dux * K_PB;
        r_y2 <= r_y1;
        r_r  <= sat(r_pr, r_y2);
        r_g  <= sat(r_pg, r_y2);
        r_b  <= sat(r_pb, r_y2);
      end
    end

    assign w_r3[gp*C_BPC +: C_BPC] = r_r;
    assign w_g3[gp*C_BPC +: C_BPC] = r_g;
    assign w_b3[gp*C_BPC +: C_BPC] = r_b;
  end

  if (C_DLY > 3) begin : g_ext
    logic [3*W-1:0] r_ext [C_DLY-3];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < C_DLY - 3; i++) r_ext[i] <= '0;
      end else begin
        r_ext[0] <= {w_r3, w_g3, w_b3};
        for (int i = 1; i < C_DLY - 3; i++) r_ext[i] <= r_ext[i-1];
      end
    end
    assign w_rgb = r_ext[C_DLY-4];
  end else begin : g_noext
    assign w_rgb = {w_r3, w_g3, w_b3};
  end

  logic [2:0] r_sync [C_DLY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < C_DLY; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= {HS_I, VS_I, DE_I};
      for (int i = 1; i < C_DLY; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign HS_O    = r_sync[C_DLY-1][2];
  assign VS_O    = r_sync[C_DLY-1][1];
  assign DE_O    = r_sync[C_DLY-1][0];
  assign w_blank = (C_BLANK_ZERO != 0) && !r_sync[C_DLY-1][0];
  assign R_O     = w_blank ? '0 : w_rgb[3*W-1:2*W];
  assign G_O     = w_blank ? '0 : w_rgb[2*W-1:W];
  assign B_O     = w_blank ? '0 : w_rgb[W-1:0];

endmodule
